watch_display_scan: RTL

- Downstream consumer of the watch time-keeping stage: takes the four BCD digits (hr1, hr0, min1, min0) and drives a 4-digit multiplexed common-anode seven-segment display.
- Contains the refresh prescaler, digit-scan rotation, per-frame snapshot of the digits, BCD-to-segment decode, set-mode field blinking and colon control.
- Sits between the watch core and the board display pins.

---
 rtl/watch_display_scan.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/watch_display_scan.sv
// watch_display_scan: 4-digit multiplexed common-anode seven-segment driver
// for the watch. It runs the refresh prescaler and digit rotation, takes a
// snapshot of the digits once per frame, and decodes BCD to segments. It
// also blanks the field being set and drives the colon.
//
// Optional build macro: LEADING_ZERO_BLANK_EN
//   defined   -> hr1 == 0 is shown blank on slot 3
//   undefined -> hr1 == 0 is shown as "0"
module watch_display_scan #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] hr1,
    input  logic [3:0] hr0,
    input  logic [3:0] min1,
    input  logic [3:0] min0,
    input  logic [1:0] blink_sel,
    input  logic       colon_en,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       frame_tick
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    logic [PW-1:0] presc_reg;
    logic [1:0]    slot_reg;
    logic [FW-1:0] frame_reg;
    logic          phase_reg;

    // The snapshot is indexed by slot, so the digit on screen is snap_reg[slot].
    logic [3:0]    digit_in [4];
    logic [3:0]    snap_reg [4];

    logic          slot_tick;
    logic          wrap;

    logic [6:0]    seg_reg, seg_next;
    logic          dp_reg, dp_next;
    logic [3:0]    an_reg, an_next;
    logic          frame_tick_reg;

    logic [3:0]    cur_digit;
    logic          field_blank;

    assign digit_in[0] = min0;
    assign digit_in[1] = min1;
    assign digit_in[2] = hr0;
    assign digit_in[3] = hr1;

    assign slot_tick = (presc_reg == PW'(SCAN_DIV - 1));
    assign wrap      = slot_tick && (slot_reg == 2'd3);

    // Active-low {g,f,e,d,c,b,a}. Non-BCD values show a dash.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        case (d)
            4'd0:    bcd_to_seg = 7'h40;
            4'd1:    bcd_to_seg = 7'h79;
            4'd2:    bcd_to_seg = 7'h24;
            4'd3:    bcd_to_seg = 7'h30;
            4'd4:    bcd_to_seg = 7'h19;
            4'd5:    bcd_to_seg = 7'h12;
            4'd6:    bcd_to_seg = 7'h02;
            4'd7:    bcd_to_seg = 7'h78;
            4'd8:    bcd_to_seg = 7'h00;
            4'd9:    bcd_to_seg = 7'h10;
            default: bcd_to_seg = SEG_DASH;
        endcase
    endfunction

    // Prescaler, slot rotation, frame counter and blink phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_reg <= '0;
            slot_reg  <= 2'd0;
            frame_reg <= '0;
            phase_reg <= 1'b0;
        end else if (slot_tick) begin
            presc_reg <= '0;
            slot_reg  <= slot_reg + 2'd1;
            if (slot_reg == 2'd3) begin
                if (frame_reg == FW'(BLINK_FRAMES - 1)) begin
                    frame_reg <= '0;
                    phase_reg <= ~phase_reg;
                end else begin
                    frame_reg <= frame_reg + FW'(1);
                end
            end
        end else begin
            presc_reg <= presc_reg + PW'(1);
        end
    end

    // Latch all four digits together at the frame wrap so that a frame never
    // mixes old and new digits.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_snap
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    snap_reg[gi] <= 4'd0;
                end else if (wrap) begin
                    snap_reg[gi] <= digit_in[gi];
                end
            end
        end
    endgenerate

    // Next display values from the current slot and snapshot. blink_sel is used live.
    always_comb begin
        an_next     = ~(4'b0001 << slot_reg);
        cur_digit   = snap_reg[slot_reg];
        field_blank = phase_reg && (slot_reg[1] ? blink_sel[1] : blink_sel[0]);
        seg_next    = field_blank ? SEG_BLANK : bcd_to_seg(cur_digit);
`ifdef LEADING_ZERO_BLANK_EN
        if ((slot_reg == 2'd3) && (cur_digit == 4'd0)) begin
            seg_next = SEG_BLANK;
        end
`endif
        dp_next = ~((slot_reg == 2'd2) && colon_en && !(phase_reg && blink_sel[1]));
    end

    // Register the outputs. frame_tick follows the wrap by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_reg         <= 4'b1111;
            seg_reg        <= SEG_BLANK;
            dp_reg         <= 1'b1;
            frame_tick_reg <= 1'b0;
        end else begin
            an_reg         <= an_next;
            seg_reg        <= seg_next;
            dp_reg         <= dp_next;
            frame_tick_reg <= wrap;
        end
    end

    assign an         = an_reg;
    assign seg        = seg_reg;
    assign dp         = dp_reg;
    assign frame_tick = frame_tick_reg;

endmodule
